uart_rst_seq: RTL and testbench

Reset and clock-enable sequencer for the UART subsystem. After system reset it holds every sub-domain (baud generator, receiver, transmitter, ...) in reset for a fixed time. It then releases the domains one at a time in index order, enabling each domain's clock one cycle after its reset lifts. It also services a four-phase soft-reset handshake from the host register block, re-running the full sequence without a system reset.

---
 rtl/uart_rst_seq.sv | 115 +++++++++++
 tb/tb_uart_rst_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rst_seq.sv
// Reset and clock-enable sequencer for the UART sub-domains: holds all domains
// in reset, releases them in index order, and re-runs on a soft-reset handshake.
module uart_rst_seq #(
  parameter int N_DOM    = 3,
  parameter int HOLD_CYC = 32,
  parameter int GAP_CYC  = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             soft_req,
  output logic             soft_ack,
  output logic [N_DOM-1:0] dom_rst_l,
  output logic [N_DOM-1:0] dom_clk_en,
  output logic             seq_busy,
  output logic             seq_done
);

  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

  typedef enum logic [1:0] {
    QUIESCE = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             soft_pend;

  // soft_pend remembers that the current sequence was started by a soft
  // request, so only that sequence raises soft_ack when it reaches RUN.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      soft_pend  <= 1'b0;
      soft_ack   <= 1'b0;
      dom_rst_l  <= '0;
      dom_clk_en <= '0;
      seq_busy   <= 1'b1;
      seq_done   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            dom_rst_l <= N_DOM'(1);
            cnt       <= '0;
            idx       <= '0;
            state     <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          // cnt counts edges since dom_rst_l[idx] rose; its enable follows one edge later
          if (cnt == '0) begin
            dom_clk_en <= dom_rst_l;
          end
          if (cnt == '0 && idx == IDX_LAST) begin
            state     <= RUN;
            seq_done  <= 1'b1;
            seq_busy  <= 1'b0;
            soft_ack  <= soft_pend;
            soft_pend <= 1'b0;
          end else if (cnt == GAP_LAST) begin
            dom_rst_l <= (dom_rst_l << 1) | N_DOM'(1);
            idx       <= idx + 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          if (soft_ack) begin
            if (!soft_req) begin
              soft_ack <= 1'b0;
            end
          end else if (soft_req) begin
            dom_clk_en <= '0;
            seq_busy   <= 1'b1;
            seq_done   <= 1'b0;
            cnt        <= '0;
            soft_pend  <= 1'b1;
            state      <= QUIESCE;
          end
        end

        QUIESCE: begin
          if (cnt == GAP_LAST) begin
            dom_rst_l <= '0;
            cnt       <= '0;
            idx       <= '0;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rst_seq.sv
// Directed bench for uart_rst_seq: default build plus a minimal N_DOM=1 build
// sharing the same clock and reset.
module tb_uart_rst_seq;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       soft_req;
  logic       soft_req1;

  logic       soft_ack0, seq_busy0, seq_done0;
  logic [2:0] dom_rst_l0, dom_clk_en0;
  logic       soft_ack1, seq_busy1, seq_done1;
  logic [0:0] dom_rst_l1, dom_clk_en1;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_n       = 0;

  always #5 clk_sys = ~clk_sys;

  uart_rst_seq dut0 (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .soft_req   (soft_req),
    .soft_ack   (soft_ack0),
    .dom_rst_l  (dom_rst_l0),
    .dom_clk_en (dom_clk_en0),
    .seq_busy   (seq_busy0),
    .seq_done   (seq_done0)
  );

  uart_rst_seq #(.N_DOM(1), .HOLD_CYC(1), .GAP_CYC(1), .CNT_W(8)) dut1 (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .soft_req   (soft_req1),
    .soft_ack   (soft_ack1),
    .dom_rst_l  (dom_rst_l1),
    .dom_clk_en (dom_clk_en1),
    .seq_busy   (seq_busy1),
    .seq_done   (seq_done1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic req);
    reset    = r;
    soft_req = req;
  endtask

  // Advance to just after edge k, counting edges since reset was released.
  task automatic runTo(input int k);
    while (edge_n < k) begin
      @(posedge clk_sys);
      #1;
      edge_n++;
    end
  endtask

  // A domain enable must never be high while that domain is held in reset.
  always @(negedge clk_sys) begin
    checkOutput("inv0", 32'(dom_clk_en0 & ~dom_rst_l0), 32'd0);
    checkOutput("inv1", 32'(dom_clk_en1 & ~dom_rst_l1), 32'd0);
  end

  task automatic checkResetVals(input string pfx);
    checkOutput({pfx, "_rst_l"},  32'(dom_rst_l0),  32'd0);
    checkOutput({pfx, "_clk_en"}, 32'(dom_clk_en0), 32'd0);
    checkOutput({pfx, "_busy"},   32'(seq_busy0),   32'd1);
    checkOutput({pfx, "_done"},   32'(seq_done0),   32'd0);
    checkOutput({pfx, "_ack"},    32'(soft_ack0),   32'd0);
    checkOutput({pfx, "_rst_l1"}, 32'(dom_rst_l1),  32'd0);
    checkOutput({pfx, "_busy1"},  32'(seq_busy1),   32'd1);
  endtask

  // Power-up timing with defaults (releases at 32/48/64, done at 65),
  // optionally pulsing soft_req during HOLD and RELEASE.
  task automatic checkPowerUp(input string pfx, input bit pulse);
    runTo(1);
    checkOutput({pfx, "_n1_rst_e1"}, 32'(dom_rst_l1),  32'd1);
    checkOutput({pfx, "_n1_en_e1"},  32'(dom_clk_en1), 32'd0);
    checkOutput({pfx, "_n1_done_e1"}, 32'(seq_done1),  32'd0);
    runTo(2);
    checkOutput({pfx, "_n1_en_e2"},   32'(dom_clk_en1), 32'd1);
    checkOutput({pfx, "_n1_done_e2"}, 32'(seq_done1),   32'd1);
    checkOutput({pfx, "_n1_busy_e2"}, 32'(seq_busy1),   32'd0);
    runTo(10);
    if (pulse) soft_req = 1'b1;
    runTo(12);
    soft_req = 1'b0;
    runTo(31);
    checkOutput({pfx, "_rst_e31"}, 32'(dom_rst_l0), 32'd0);
    runTo(32);
    checkOutput({pfx, "_rst_e32"}, 32'(dom_rst_l0),  32'd1);
    checkOutput({pfx, "_en_e32"},  32'(dom_clk_en0), 32'd0);
    runTo(33);
    checkOutput({pfx, "_en_e33"},  32'(dom_clk_en0), 32'd1);
    runTo(40);
    if (pulse) soft_req = 1'b1;
    runTo(42);
    soft_req = 1'b0;
    runTo(47);
    checkOutput({pfx, "_rst_e47"}, 32'(dom_rst_l0),  32'd1);
    runTo(48);
    checkOutput({pfx, "_rst_e48"}, 32'(dom_rst_l0),  32'd3);
    checkOutput({pfx, "_en_e48"},  32'(dom_clk_en0), 32'd1);
    runTo(49);
    checkOutput({pfx, "_en_e49"},  32'(dom_clk_en0), 32'd3);
    runTo(64);
    checkOutput({pfx, "_rst_e64"},  32'(dom_rst_l0),  32'd7);
    checkOutput({pfx, "_en_e64"},   32'(dom_clk_en0), 32'd3);
    checkOutput({pfx, "_done_e64"}, 32'(seq_done0),   32'd0);
    checkOutput({pfx, "_busy_e64"}, 32'(seq_busy0),   32'd1);
    runTo(65);
    checkOutput({pfx, "_en_e65"},   32'(dom_clk_en0), 32'd7);
    checkOutput({pfx, "_done_e65"}, 32'(seq_done0),   32'd1);
    checkOutput({pfx, "_busy_e65"}, 32'(seq_busy0),   32'd0);
    checkOutput({pfx, "_ack_e65"},  32'(soft_ack0),   32'd0);
  endtask

  initial begin
    soft_req1 = 1'b0;
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(posedge clk_sys);
    #1;
    checkResetVals("por");
    applyStimulus(1'b0, 1'b0);
    edge_n = 0;
    checkPowerUp("pwr", 1'b0);

    // Soft reset accepted at edge 71
    runTo(70);
    applyStimulus(1'b0, 1'b1);
    runTo(71);
    checkOutput("soft_en_S",   32'(dom_clk_en0), 32'd0);
    checkOutput("soft_done_S", 32'(seq_done0),   32'd0);
    checkOutput("soft_busy_S", 32'(seq_busy0),   32'd1);
    checkOutput("soft_rst_S",  32'(dom_rst_l0),  32'd7);
    runTo(86);
    checkOutput("soft_rst_S15", 32'(dom_rst_l0), 32'd7);
    runTo(87);
    checkOutput("soft_rst_S16", 32'(dom_rst_l0), 32'd0);
    runTo(119);
    checkOutput("soft_rst_S48", 32'(dom_rst_l0), 32'd1);
    runTo(135);
    checkOutput("soft_rst_S64", 32'(dom_rst_l0), 32'd3);
    runTo(151);
    checkOutput("soft_rst_S80",  32'(dom_rst_l0), 32'd7);
    checkOutput("soft_done_S80", 32'(seq_done0),  32'd0);
    checkOutput("soft_ack_S80",  32'(soft_ack0),  32'd0);
    runTo(152);
    checkOutput("soft_done_S81", 32'(seq_done0),   32'd1);
    checkOutput("soft_ack_S81",  32'(soft_ack0),   32'd1);
    checkOutput("soft_en_S81",   32'(dom_clk_en0), 32'd7);
    checkOutput("soft_busy_S81", 32'(seq_busy0),   32'd0);

    // soft_req held high: no second sequence
    runTo(161);
    checkOutput("hold_ack",  32'(soft_ack0),   32'd1);
    checkOutput("hold_en",   32'(dom_clk_en0), 32'd7);
    checkOutput("hold_busy", 32'(seq_busy0),   32'd0);
    applyStimulus(1'b0, 1'b0);
    runTo(162);
    checkOutput("drop_ack",  32'(soft_ack0), 32'd0);
    checkOutput("drop_done", 32'(seq_done0), 32'd1);

    // New request accepted at edge 165
    runTo(164);
    applyStimulus(1'b0, 1'b1);
    runTo(165);
    checkOutput("soft2_en_S",   32'(dom_clk_en0), 32'd0);
    checkOutput("soft2_busy_S", 32'(seq_busy0),   32'd1);
    runTo(245);
    checkOutput("soft2_ack_S80", 32'(soft_ack0), 32'd0);
    runTo(246);
    checkOutput("soft2_ack_S81",  32'(soft_ack0), 32'd1);
    checkOutput("soft2_done_S81", 32'(seq_done0), 32'd1);

    // System reset while soft_ack is high clears it
    applyStimulus(1'b1, 1'b1);
    @(posedge clk_sys);
    #1;
    checkResetVals("ackrst");
    applyStimulus(1'b1, 1'b0);
    @(posedge clk_sys);
    #1;
    applyStimulus(1'b0, 1'b0);
    edge_n = 0;
    checkPowerUp("busyreq", 1'b1);

    // Reset sampled at edge 40 during RELEASE
    applyStimulus(1'b1, 1'b0);
    @(posedge clk_sys);
    #1;
    applyStimulus(1'b0, 1'b0);
    edge_n = 0;
    runTo(39);
    checkOutput("mid_rst_e39", 32'(dom_rst_l0), 32'd1);
    applyStimulus(1'b1, 1'b0);
    runTo(40);
    checkResetVals("mid");
    applyStimulus(1'b0, 1'b0);
    edge_n = 0;
    checkPowerUp("rerun", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
